alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the operand/result width in bits; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to launch an operation.
REQ-005 The block SHALL have port A, input, W bits: first operand.
REQ-006 The block SHALL have port B, input, W bits: second operand; for shifts, the amount is B[log2(W)-1:0].
REQ-007 The block SHALL have port f, input, 4 bits: opcode.
- f[3:2]=01 arithmetic: ADD, SUB, INC A, DEC A.
- f[3:2]=10 logic: AND, OR, XOR, NOR.
- f[3:2]=11: SLL, SRL, SRA, MUL.
- f[3:2]=00: reserved.
REQ-008 The block SHALL have port S, output, W bits: registered result.
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse marking S and the flags valid.
REQ-011 The block SHALL have ports sig_Z, sig_C and sig_O, outputs, 1 bit each: registered zero, carry and overflow flags.

Function
REQ-012 An operation SHALL be accepted on a rising edge where start=1 and the block is in state IDLE or DONE; A, B and f SHALL be captured at that edge.
REQ-013 start SHALL be ignored while busy=1, and a change on A, B or f after the accept edge SHALL NOT affect the operation in flight.
REQ-014 The state machine SHALL have states IDLE, SHIFT, MUL and DONE.
- IDLE/DONE to SHIFT: on accepting a shift with amount N>0.
- IDLE/DONE to MUL: on accepting MUL.
- All other accepts: directly to DONE.
- SHIFT/MUL to DONE: when the iteration count is exhausted.
- DONE to IDLE: when start=0.
REQ-015 done SHALL be 1 for exactly the one cycle after an operation completes.
- Result ready L edges after accept.
- L=1 for arithmetic, logic and reserved ops.
- L=max(N,1) for shifts.
- L=W for MUL.
REQ-016 busy SHALL be 1 from the accept edge until the edge on which done rises.
REQ-017 S and the flags SHALL hold their values until the next completion.
REQ-018 Arithmetic SHALL be W-bit modulo.
- sig_C is the carry out; for SUB/DEC it is the carry of A+~B+1, so 1 means no borrow.
- sig_O is two's-complement signed overflow.
REQ-019 Logic ops SHALL force sig_C=0 and sig_O=0.
REQ-020 Shifts SHALL move one bit per cycle.
- sig_C is the last bit shifted out, and 0 when N=0.
- sig_O=0.
- SRA replicates the MSB.
REQ-021 MUL SHALL be unsigned shift-add over W cycles.
- S is the low W bits of the product.
- sig_O=1 if the high W bits are nonzero.
- sig_C=0.
REQ-022 Reserved opcodes SHALL produce S=0, sig_Z=1 and sig_C=sig_O=0 with L=1.
REQ-023 sig_Z SHALL equal 1 exactly when the final S is all zeros, for every opcode.

Reset
REQ-024 Asserting rst_n=0 SHALL, without waiting for clk, force state IDLE and set S=0, busy=0, done=0, sig_Z=0, sig_C=0 and sig_O=0, aborting any operation in flight.
REQ-025 The first edge after rst_n is deasserted SHALL be able to accept start.

Configuration
REQ-026 When macro ALU_SEQ_MUL_EN is defined, the MUL opcode (f=1111) and the MUL state SHALL be built.
REQ-027 When ALU_SEQ_MUL_EN is undefined, f=1111 SHALL behave as a reserved opcode (REQ-022), and no multiplier logic or MUL state SHALL exist.

Structure
REQ-028 Package alu_seq_pkg SHALL hold the opcode class and operation constants and the state enumeration type.
REQ-029 The W-bit add/subtract with carry and overflow SHALL be one sub-module, alu_seq_addsub; the add/subtract path of MUL SHALL reuse it.

Verification (W=32)
REQ-030 ADD, A=0x7FFFFFFF, B=1 -> one cycle later: done=1, S=0x80000000, O=1, C=0, Z=0.
REQ-031 SUB, A=B=5 -> S=0, Z=1, C=1, O=0, L=1.
REQ-032 SRA, A=0x80000000, B=4 -> done 4 edges after accept: S=0xF8000000, C=0; start pulses during busy are ignored.
REQ-033 MUL, A=B=0x00010000, macro defined -> after 32 edges: S=0, Z=1, O=1; with the macro undefined: S=0, Z=1, L=1.
REQ-034 rst_n pulled low mid-SRL -> busy, done, S and the flags are 0 before the next clk edge; a fresh ADD after release completes normally.
REQ-035 start held high through DONE -> a second ADD is accepted on the done cycle and its done pulse follows one edge later.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the sequential ALU.
//   op_class_e : opcode class carried in f[3:2]
//   OP_*       : operation selected by f[1:0] inside each class
//   F_MUL      : full opcode of the multiply
//   state_e    : controller states. ST_MUL exists only when ALU_SEQ_MUL_EN is defined.
// Configuration macro: ALU_SEQ_MUL_EN (builds the shift-add multiplier).
package alu_seq_pkg;

  typedef enum logic [1:0] {
    CLS_RSVD  = 2'b00,
    CLS_ARITH = 2'b01,
    CLS_LOGIC = 2'b10,
    CLS_SHIFT = 2'b11
  } op_class_e;

  // Arithmetic class
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;
  // Logic class
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;
  // Shift class
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [3:0] F_MUL = 4'b1111;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_DONE} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
`endif

endpackage

// File: rtl/alu_seq_addsub.sv
// alu_seq_addsub -- W-bit adder/subtractor with carry and signed overflow.
//   x, y  : operands
//   sub   : 1 computes x + ~y + 1 (carry=1 means no borrow)
//   sum   : W-bit modulo result
//   carry : carry out of the MSB
//   ovf   : two's-complement overflow
module alu_seq_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         ovf
);

  logic [W-1:0] y_eff;

  assign y_eff        = sub ? ~y : y;
  assign {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};
  // Overflow: both addends share a sign that the sum does not.
  assign ovf          = (x[W-1] == y_eff[W-1]) && (sum[W-1] != x[W-1]);

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU: single-cycle arithmetic/logic, bit-serial
// shifts and (optionally) a W-cycle unsigned shift-add multiplier.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : launch request, honoured only when idle/done and not busy
//   A, B, f        : operands and opcode, captured on the accept edge
//   S              : registered result
//   busy           : operation in flight (accept edge up to the done edge)
//   done           : one-cycle pulse, S and flags valid
//   sig_Z/C/O      : registered zero, carry, overflow flags
// Configuration macro: ALU_SEQ_MUL_EN builds the multiplier and ST_MUL;
// without it f=1111 behaves as a reserved opcode.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   f,
  output logic [W-1:0] S,
  output logic         busy,
  output logic         done,
  output logic         sig_Z,
  output logic         sig_C,
  output logic         sig_O
);

  localparam int SW = $clog2(W);
  localparam int CW = SW + 1;

  state_e         state, state_nx;
  logic [W-1:0]   a_q, b_q, acc_q, a_nx, b_nx, acc_nx, s_nx;
  logic [3:0]     f_q, f_nx;
  logic [CW-1:0]  cnt_q, cnt_nx;
  logic           busy_nx, done_nx, z_nx, c_nx, o_nx, accept;
  logic [W-1:0]   as_x, as_y, as_sum;
  logic           as_sub, as_carry, as_ovf;
  logic [W-1:0]   alu_s, sh_val;
  logic           alu_c, alu_o, sh_c;
`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]   lo_q, lo_nx;
`endif

  // Adder is shared: operand path for ADD/SUB/INC/DEC, partial-product
  // accumulate while multiplying.
  always_comb begin
    as_x   = a_q;
    as_y   = f_q[1] ? W'(1) : b_q;
    as_sub = f_q[0];
`ifdef ALU_SEQ_MUL_EN
    if (state == ST_MUL) begin
      as_x   = acc_q;
      as_y   = lo_q[0] ? a_q : '0;
      as_sub = 1'b0;
    end
`endif
  end

  alu_seq_addsub #(.W(W)) u_addsub (
    .x     (as_x),
    .y     (as_y),
    .sub   (as_sub),
    .sum   (as_sum),
    .carry (as_carry),
    .ovf   (as_ovf)
  );

  // Single-cycle results, computed from the captured operands.
  always_comb begin
    alu_s = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    case (op_class_e'(f_q[3:2]))
      CLS_ARITH: begin
        alu_s = as_sum;
        alu_c = as_carry;
        alu_o = as_ovf;
      end
      CLS_LOGIC: begin
        case (f_q[1:0])
          OP_AND:  alu_s = a_q & b_q;
          OP_OR:   alu_s = a_q | b_q;
          OP_XOR:  alu_s = a_q ^ b_q;
          default: alu_s = ~(a_q | b_q);
        endcase
      end
      // Only zero-length shifts finish here; f=1111 lands here only as reserved.
      CLS_SHIFT: alu_s = (f_q[1:0] == OP_MUL) ? '0 : a_q;
      default:   alu_s = '0;
    endcase
  end

  // One-bit shift step with the bit that falls out.
  always_comb begin
    case (f_q[1:0])
      OP_SLL: begin
        sh_val = {acc_q[W-2:0], 1'b0};
        sh_c   = acc_q[W-1];
      end
      OP_SRL: begin
        sh_val = {1'b0, acc_q[W-1:1]};
        sh_c   = acc_q[0];
      end
      default: begin
        sh_val = {acc_q[W-1], acc_q[W-1:1]};
        sh_c   = acc_q[0];
      end
    endcase
  end

  always_comb begin
    // NOTE: every variable of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    busy_nx  = busy;
    done_nx  = 1'b0;
    s_nx     = S;
    z_nx     = sig_Z;
    c_nx     = sig_C;
    o_nx     = sig_O;
    a_nx     = a_q;
    b_nx     = b_q;
    f_nx     = f_q;
    acc_nx   = acc_q;
    cnt_nx   = cnt_q;
`ifdef ALU_SEQ_MUL_EN
    lo_nx    = lo_q;
`endif
    accept   = start && !busy && (state == ST_IDLE || state == ST_DONE);

    case (state)
      ST_SHIFT: begin
        acc_nx = sh_val;
        cnt_nx = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_nx = ST_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          s_nx     = sh_val;
          c_nx     = sh_c;
          o_nx     = 1'b0;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      // acc holds the product high half, lo the multiplier draining into the low half.
      ST_MUL: begin
        acc_nx = {as_carry, as_sum[W-1:1]};
        lo_nx  = {as_sum[0], lo_q[W-1:1]};
        cnt_nx = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_nx = ST_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          s_nx     = lo_nx;
          c_nx     = 1'b0;
          o_nx     = |acc_nx;
        end
      end
`endif
      // DONE while busy is the compute cycle of a single-cycle op.
      ST_DONE: begin
        if (busy) begin
          busy_nx = 1'b0;
          done_nx = 1'b1;
          s_nx    = alu_s;
          c_nx    = alu_c;
          o_nx    = alu_o;
        end else if (!start) begin
          state_nx = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      a_nx     = A;
      b_nx     = B;
      f_nx     = f;
      acc_nx   = A;
      busy_nx  = 1'b1;
      cnt_nx   = '0;
      state_nx = ST_DONE;
      if (f[3:2] == CLS_SHIFT && f[1:0] != OP_MUL && B[SW-1:0] != '0) begin
        state_nx = ST_SHIFT;
        cnt_nx   = {1'b0, B[SW-1:0]};
      end
`ifdef ALU_SEQ_MUL_EN
      if (f == F_MUL) begin
        state_nx = ST_MUL;
        cnt_nx   = CW'(W);
        acc_nx   = '0;
        lo_nx    = B;
      end
`endif
    end

    if (done_nx) z_nx = (s_nx == '0);
  end

  // NOTE: state registers update with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      sig_Z <= 1'b0;
      sig_C <= 1'b0;
      sig_O <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      f_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
`ifdef ALU_SEQ_MUL_EN
      lo_q  <= '0;
`endif
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      S     <= s_nx;
      sig_Z <= z_nx;
      sig_C <= c_nx;
      sig_O <= o_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      f_q   <= f_nx;
      acc_q <= acc_nx;
      cnt_q <= cnt_nx;
`ifdef ALU_SEQ_MUL_EN
      lo_q  <= lo_nx;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- scoreboard bench for alu_seq (W=32). Stimulus pushes the
// reference-model result and expected done edge into a queue; a monitor
// on the falling edge pops and compares whenever done appears or is due.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] F_ADD = 4'b0100, F_SUB = 4'b0101, F_INC = 4'b0110, F_DEC = 4'b0111;
  localparam logic [3:0] F_SLL = 4'b1100, F_SRL = 4'b1101, F_SRA = 4'b1110, F_MUL = 4'b1111;

  typedef struct {
    logic [W-1:0] s;
    bit           z, c, o;
    int           lat;
    int           acc_edge;
    int           done_edge;
  } exp_t;

  logic         clk, rst_n, start;
  logic [W-1:0] A, B, S;
  logic [3:0]   f;
  logic         busy, done, sig_Z, sig_C, sig_O;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  exp_t q[$];
  exp_t mon_e;

  alu_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .f     (f),
    .S     (S),
    .busy  (busy),
    .done  (done),
    .sig_Z (sig_Z),
    .sig_C (sig_C),
    .sig_O (sig_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic on the whole operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t         r;
    longint       sa, sb, sr;
    logic [W:0]   wide;
    logic [63:0]  p;
    int           n;
    r  = '{default: 0};
    r.lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = 0;
    n  = int'(b[4:0]);
    case (op)
      F_ADD: begin wide = {1'b0, a} + {1'b0, b}; r.s = wide[W-1:0]; r.c = wide[W]; sr = sa + sb; end
      F_SUB: begin r.s = a - b; r.c = (a >= b); sr = sa - sb; end
      F_INC: begin r.s = a + 1; r.c = (a == 32'hFFFF_FFFF); sr = sa + 1; end
      F_DEC: begin r.s = a - 1; r.c = (a != 0); sr = sa - 1; end
      4'b1000: r.s = a & b;
      4'b1001: r.s = a | b;
      4'b1010: r.s = a ^ b;
      4'b1011: r.s = ~(a | b);
      F_SLL: begin
        p = {32'b0, a} << n;
        r.s = p[W-1:0];
        r.c = (n > 0) ? p[W] : 1'b0;
        r.lat = (n > 0) ? n : 1;
      end
      F_SRL, F_SRA: begin
        r.s = (op == F_SRL) ? (a >> n) : W'($signed(a) >>> n);
        r.c = (n > 0) ? a[n-1] : 1'b0;
        r.lat = (n > 0) ? n : 1;
      end
`ifdef ALU_SEQ_MUL_EN
      F_MUL: begin
        p = 64'(a) * 64'(b);
        r.s = p[W-1:0];
        r.o = (p[63:32] != 0);
        r.lat = W;
      end
`endif
      default: r.s = '0;
    endcase
    if (op[3:2] == 2'b01) r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z = (r.s == 0);
    return r;
  endfunction

  // Launch one op and ride out its latency with junk on the inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t e;
    @(negedge clk);
    A = a; B = b; f = op; start = 1'b1;
    e = model(a, b, op);
    e.acc_edge  = cyc + 1;
    e.done_edge = cyc + 1 + e.lat;
    q.push_back(e);
    @(posedge clk);
    for (int i = 0; i < e.lat; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      A = $urandom; B = $urandom; f = 4'($urandom_range(0, 15));
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (done || (q.size() > 0 && cyc >= q[0].done_edge)) begin
        if (q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("done_edge", 64'(cyc), 64'(mon_e.done_edge));
          check("done", 64'(done), 64'd1);
          if (done) begin
            check("S", 64'(S), 64'(mon_e.s));
            check("sig_Z", 64'(sig_Z), 64'(mon_e.z));
            check("sig_C", 64'(sig_C), 64'(mon_e.c));
            check("sig_O", 64'(sig_O), 64'(mon_e.o));
          end
        end
      end
      check("busy", 64'(busy),
            64'(q.size() > 0 && q[0].acc_edge <= cyc && cyc < q[0].done_edge));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; A = '0; B = '0; f = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_S", 64'(S), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_Z", 64'(sig_Z), 64'd0);
    check("rst_C", 64'(sig_C), 64'd0);
    check("rst_O", 64'(sig_O), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Corner cases
    issue(32'h7FFF_FFFF, 32'h1, F_ADD);
    issue(32'h5, 32'h5, F_SUB);
    issue(32'h8000_0000, 32'h4, F_SRA);
    issue(32'h0001_0000, 32'h0001_0000, F_MUL);
    issue(32'h1234_5678, 32'h1111_1111, F_ADD);   // back-to-back with the next
    issue(32'hFFFF_FFFF, 32'h1, F_ADD);
    issue(32'hDEAD_BEEF, 32'h20, F_SRL);          // amount field is 0
    issue(32'h8000_0001, 32'h1F, F_SLL);
    issue(32'h0, 32'h0, F_DEC);
    issue(32'hABCD_EF01, 32'h1234_5678, 4'b0010); // reserved
    issue(32'h1, 32'h2, F_ADD);

    // Reset mid-SRL
    @(negedge clk); start = 1'b0; #1 mon_en = 1'b0;
    @(negedge clk);
    A = 32'hFFFF_FFFF; B = 32'd20; f = F_SRL; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("mid_srl_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_S", 64'(S), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_Z", 64'(sig_Z), 64'd0);
    check("abort_C", 64'(sig_C), 64'd0);
    check("abort_O", 64'(sig_O), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    issue(32'h0000_1234, 32'h0000_0001, F_ADD);   // accepted on first edge after release

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      issue(a, b, op);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(1);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
